// File: rtl/mintz80_mmu_paged.sv
// mintz80_mmu_paged: paged MMU for the MintZ80 board.
// Splits the 64 KB Z80 address space into 2^PAGE_BITS pages, maps each page
// to a BANK_W-bit physical bank (ROM below ROM_BANKS, RAM otherwise), guards
// the page registers with a two-byte unlock key and provides a square-wave
// beeper. IO window: IO_BASE..IO_BASE+15.
// Optional build macro: MMU_READBACK_EN adds readback of PAGE and TONE
// registers; without it only the KEY status register is readable.
module mintz80_mmu_paged #(
    parameter int          PAGE_BITS = 3,
    parameter int          BANK_W    = 8,
    parameter int          ROM_BANKS = 4,
    parameter logic [7:0]  IO_BASE   = 8'hD0,
    parameter int          DIV_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m1_n,
    input  logic              iorq_n,
    input  logic              mreq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [15:0]       addr,
    inout  wire  [7:0]        data,
    output logic [BANK_W-1:0] ba,
    output logic              rom_cs_n,
    output logic              ram_cs_n,
    output logic              beep,
    output logic              unlocked
);

    localparam int          NPAGES  = 1 << PAGE_BITS;
    localparam int          WB      = (BANK_W < 8) ? BANK_W : 8;
    localparam int unsigned ROM_LIM = ROM_BANKS;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_KEY1     = 2'd1,
        ST_UNLOCKED = 2'd2
    } lock_state_e;

    lock_state_e          state_q, state_d;
    logic                 strobe_q;
    logic [BANK_W-1:0]    page_q [NPAGES];
    logic [BANK_W-1:0]    page_d [NPAGES];
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 en_q, en_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic                 beep_q, beep_d;

    logic                 io_win_s;
    logic                 wr_strobe_s;
    logic                 wr_evt_s;
    logic [3:0]           off_s;
    logic                 key_wr_s;
    logic                 tlo_wr_s;
    logic                 thi_wr_s;
    logic                 page_hit_s;
    logic                 page_wr_s;
    logic [PAGE_BITS-1:0] page_sel_s;
    logic [BANK_W-1:0]    wdata_s;
    logic                 rd_act_s;
    logic                 rd_hit_s;
    logic [7:0]           rd_data_s;
    logic                 unused_addr_s;

    // Reset value of each page: page 0 is bank 0, the rest follow ROM_BANKS.
    function automatic logic [BANK_W-1:0] page_rst(input int idx);
        logic [31:0] v;
        if (idx == 0) begin
            v = 32'd0;
        end else begin
            v = 32'(ROM_BANKS + idx - 1);
        end
        return v[BANK_W-1:0];
    endfunction

    assign unused_addr_s = ^addr;

    // IO decode and single-shot write event detection.
    always_comb begin
        off_s       = addr[3:0];
        io_win_s    = (addr[7:4] == IO_BASE[7:4]);
        wr_strobe_s = io_win_s & ~iorq_n & ~wr_n & m1_n;
        wr_evt_s    = wr_strobe_s & ~strobe_q;
        key_wr_s    = wr_evt_s & (off_s == 4'd2);
        tlo_wr_s    = wr_evt_s & (off_s == 4'd0);
        thi_wr_s    = wr_evt_s & (off_s == 4'd1);
        page_hit_s  = off_s[3] & ({1'b0, off_s[2:0]} < 4'(NPAGES));
        page_sel_s  = off_s[PAGE_BITS-1:0];
        page_wr_s   = wr_evt_s & page_hit_s & (state_q == ST_UNLOCKED);
        wdata_s          = {BANK_W{1'b0}};
        wdata_s[WB-1:0]  = data[WB-1:0];
    end

    // Previous-strobe register so a held strobe yields a single write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= wr_strobe_s;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock FSM next state: A5 then 5A unlocks; any stray write aborts KEY1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOCKED: begin
                if (key_wr_s && (data == 8'hA5)) begin
                    state_d = ST_KEY1;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_KEY1: begin
                if (key_wr_s && (data == 8'h5A)) begin
                    state_d = ST_UNLOCKED;
                end else if (wr_evt_s) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_KEY1;
                end
            end
            ST_UNLOCKED: begin
                if (key_wr_s) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    assign unlocked = (state_q == ST_UNLOCKED);

    // Page register next state: writes land only while unlocked.
    always_comb begin
        for (int i = 0; i < NPAGES; i++) begin
            page_d[i] = page_q[i];
        end
        if (page_wr_s) begin
            page_d[page_sel_s] = wdata_s;
        end else begin
            page_d[page_sel_s] = page_q[page_sel_s];
        end
    end

    // Page registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPAGES; i++) begin
                page_q[i] <= page_rst(i);
            end
        end else begin
            for (int i = 0; i < NPAGES; i++) begin
                page_q[i] <= page_d[i];
            end
        end
    end

    // Combinational mapping: bank of the current page and chip selects.
    always_comb begin
        ba       = page_q[addr[15:16-PAGE_BITS]];
        rom_cs_n = mreq_n | (32'(ba) >= ROM_LIM);
        ram_cs_n = mreq_n | (32'(ba) <  ROM_LIM);
    end

    // Tone register next state; TONE writes are never locked.
    always_comb begin
        div_d = div_q;
        en_d  = en_q;
        if (tlo_wr_s) begin
            div_d[7:0] = data;
        end else if (thi_wr_s) begin
            en_d             = data[7];
            div_d[DIV_W-1:8] = data[DIV_W-9:0];
        end else begin
            div_d = div_q;
        end
    end

    // Beeper next state: down-counter toggling beep each divider+1 clocks.
    always_comb begin
        cnt_d  = cnt_q;
        beep_d = beep_q;
        if (tlo_wr_s || thi_wr_s) begin
            cnt_d = div_d;
        end else if (!en_q || (div_q == {DIV_W{1'b0}})) begin
            cnt_d  = {DIV_W{1'b0}};
            beep_d = 1'b0;
        end else if (cnt_q == {DIV_W{1'b0}}) begin
            cnt_d  = div_q;
            beep_d = ~beep_q;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Tone and beeper registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= {DIV_W{1'b0}};
            en_q   <= 1'b0;
            cnt_q  <= {DIV_W{1'b0}};
            beep_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            beep_q <= beep_d;
        end
    end

    assign beep = beep_q;

    // Read decode: only readable offsets drive the bus, never in reset.
    always_comb begin
        rd_act_s  = reset & io_win_s & ~iorq_n & ~rd_n & m1_n;
        rd_hit_s  = 1'b0;
        rd_data_s = 8'h00;
        case (off_s)
            4'd2: begin
                rd_hit_s  = 1'b1;
                rd_data_s = {7'b0000000, unlocked};
            end
`ifdef MMU_READBACK_EN
            4'd0: begin
                rd_hit_s  = 1'b1;
                rd_data_s = div_q[7:0];
            end
            4'd1: begin
                rd_hit_s                = 1'b1;
                rd_data_s[7]            = en_q;
                rd_data_s[DIV_W-9:0]    = div_q[DIV_W-1:8];
            end
            default: begin
                if (page_hit_s) begin
                    rd_hit_s           = 1'b1;
                    rd_data_s[WB-1:0]  = page_q[page_sel_s][WB-1:0];
                end else begin
                    rd_hit_s  = 1'b0;
                    rd_data_s = 8'h00;
                end
            end
`else
            default: begin
                rd_hit_s  = 1'b0;
                rd_data_s = 8'h00;
            end
`endif
        endcase
    end

    assign data = (rd_act_s && rd_hit_s) ? rd_data_s : 8'hzz;

endmodule

// File: tb/tb_mintz80_mmu_paged.sv
// Directed, table-driven bench for mintz80_mmu_paged (default parameters).
// A pull-up on the data bus makes an undriven bus read as 8'hFF.
module tb_mintz80_mmu_paged;

    localparam logic [1:0] OP_MEM   = 2'd0;
    localparam logic [1:0] OP_NOMEM = 2'd1;
    localparam logic [1:0] OP_WR    = 2'd2;
    localparam logic [1:0] OP_RD    = 2'd3;

`ifdef MMU_READBACK_EN
    localparam logic [7:0] RB_D9 = 8'h04;
    localparam logic [7:0] RB_D8 = 8'h10;
`else
    localparam logic [7:0] RB_D9 = 8'hFF;
    localparam logic [7:0] RB_D8 = 8'hFF;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_ba;
        logic        exp_rom_n;
        logic        exp_ram_n;
        logic        exp_unl;
        logic [7:0]  exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m1_n = 1'b1;
    logic        iorq_n = 1'b1;
    logic        mreq_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  tb_drv = 8'h00;
    logic        tb_oe = 1'b0;
    wire  [7:0]  data_w;
    logic [7:0]  ba;
    logic        rom_cs_n;
    logic        ram_cs_n;
    logic        beep;
    logic        unlocked;

    int n_vec = 0;
    int n_err = 0;
    vec_t vq[$];

    assign data_w = tb_oe ? tb_drv : 8'hzz;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (data_w[gi]);
    end

    always #5 clk = ~clk;

    mintz80_mmu_paged dut (
        .clk      (clk),
        .reset    (reset),
        .m1_n     (m1_n),
        .iorq_n   (iorq_n),
        .mreq_n   (mreq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .addr     (addr),
        .data     (data_w),
        .ba       (ba),
        .rom_cs_n (rom_cs_n),
        .ram_cs_n (ram_cs_n),
        .beep     (beep),
        .unlocked (unlocked)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                       input logic [7:0] eba, input logic erom, input logic eram,
                       input logic eunl, input logic [7:0] erd);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.exp_ba = eba; v.exp_rom_n = erom;
        v.exp_ram_n = eram; v.exp_unl = eunl; v.exp_rd = erd;
        vq.push_back(v);
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        addr = {8'h00, a}; tb_drv = d; tb_oe = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic io_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = {8'h00, a}; iorq_n = 1'b0; rd_n = 1'b0;
        #1 d = data_w;
        iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic mem_at(input logic [15:0] a);
        @(negedge clk);
        addr = a; mreq_n = 1'b0;
        #1;
    endtask

    logic [7:0] rd_v;
    int         tog_t[$];
    int         seen_hi;
    logic       prev_beep;

    initial begin
        // Vector table: {op, addr, wdata, ba, rom_cs_n, ram_cs_n, unlocked, read data}
        add(OP_MEM,   16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        add(OP_MEM,   16'h2000, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00);
        add(OP_MEM,   16'hE000, 8'h00, 8'h0A, 1'b1, 1'b0, 1'b0, 8'h00);
        add(OP_RD,    16'h00D2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_RD,    16'h00D9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, RB_D9);
        add(OP_RD,    16'h00D5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF);
        add(OP_WR,    16'h00D8, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_MEM,   16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        add(OP_WR,    16'h00D2, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_WR,    16'h00D2, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        add(OP_RD,    16'h00D2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01);
        add(OP_WR,    16'h00D8, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        add(OP_MEM,   16'h0000, 8'h00, 8'h10, 1'b1, 1'b0, 1'b1, 8'h00);
        add(OP_MEM,   16'h1FFF, 8'h00, 8'h10, 1'b1, 1'b0, 1'b1, 8'h00);
        add(OP_NOMEM, 16'h0000, 8'h00, 8'h10, 1'b1, 1'b1, 1'b1, 8'h00);
        add(OP_RD,    16'h00D8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, RB_D8);
        add(OP_WR,    16'h00DF, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        add(OP_MEM,   16'hFFFF, 8'h00, 8'h03, 1'b0, 1'b1, 1'b1, 8'h00);
        add(OP_MEM,   16'hDFFF, 8'h00, 8'h09, 1'b1, 1'b0, 1'b1, 8'h00);
        add(OP_WR,    16'h00C2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        add(OP_WR,    16'h00D3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        add(OP_WR,    16'h00D2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_WR,    16'h00D9, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_MEM,   16'h2000, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00);
        add(OP_WR,    16'h00D2, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_WR,    16'h00D0, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_WR,    16'h00D2, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_MEM,   16'h0000, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00);
        add(OP_WR,    16'h00D2, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(OP_WR,    16'h00D2, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

        // Reset
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("rst_beep", 32'(beep), 32'd0);

        // Table
        for (int i = 0; i < vq.size(); i++) begin
            case (vq[i].op)
                OP_MEM, OP_NOMEM: begin
                    @(negedge clk);
                    addr = vq[i].a;
                    mreq_n = (vq[i].op == OP_NOMEM);
                    #1 chk($sformatf("vec%0d_map", i),
                           32'({ba, rom_cs_n, ram_cs_n, unlocked}),
                           32'({vq[i].exp_ba, vq[i].exp_rom_n, vq[i].exp_ram_n, vq[i].exp_unl}));
                    mreq_n = 1'b1;
                end
                OP_WR: begin
                    io_wr(vq[i].a[7:0], vq[i].d, 2);
                    #1 chk($sformatf("vec%0d_unl", i), 32'(unlocked), 32'(vq[i].exp_unl));
                end
                default: begin
                    io_rd(vq[i].a[7:0], rd_v);
                    chk($sformatf("vec%0d_rd", i), 32'({rd_v, unlocked}),
                        32'({vq[i].exp_rd, vq[i].exp_unl}));
                end
            endcase
        end

        // Interrupt acknowledge (M1 + IORQ) cycles change nothing
        @(negedge clk);
        m1_n = 1'b0; addr = 16'h00D2; tb_drv = 8'h00; tb_oe = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        addr = 16'h00D8; tb_drv = 8'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
        #1 chk("m1_unl", 32'(unlocked), 32'd1);
        @(negedge clk);
        addr = 16'h00D2; iorq_n = 1'b0; rd_n = 1'b0;
        #1 chk("m1_rd_z", 32'(data_w), 32'hFF);
        iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
        mem_at(16'h0000);
        chk("m1_page0", 32'(ba), 32'h10);
        mreq_n = 1'b1;

        // Held strobe in UNLOCKED: exactly one lock transition
        @(negedge clk);
        addr = 16'h00D2; tb_drv = 8'h00; tb_oe = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge clk); #1 chk("hold_first", 32'(unlocked), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
        #1 chk("hold_end", 32'(unlocked), 32'd0);
        // Held A5 for 4 clk must count once, so 5A then unlocks
        @(negedge clk);
        addr = 16'h00D2; tb_drv = 8'hA5; tb_oe = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
        io_wr(8'hD2, 8'h5A, 2);
        #1 chk("hold_a5_once", 32'(unlocked), 32'd1);

        // Beeper: divider 3 -> half-period 4 clocks
        io_wr(8'hD0, 8'h03, 2);
        io_wr(8'hD1, 8'h80, 2);
        prev_beep = beep;
        for (int c = 0; c < 60 && tog_t.size() < 4; c++) begin
            @(negedge clk);
            if (beep !== prev_beep) tog_t.push_back(c);
            prev_beep = beep;
        end
        chk("beep_toggles", 32'(tog_t.size()), 32'd4);
        for (int k = 1; k < tog_t.size(); k++) begin
            chk($sformatf("beep_half%0d", k), 32'(tog_t[k] - tog_t[k-1]), 32'd4);
        end
        io_wr(8'hD1, 8'h00, 2);
        #1 chk("beep_off", 32'(beep), 32'd0);
        seen_hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (beep) seen_hi = 1;
        end
        chk("beep_stays_off", 32'(seen_hi), 32'd0);
        // Divider 0 with enable keeps beep low
        io_wr(8'hD0, 8'h00, 2);
        io_wr(8'hD1, 8'h80, 2);
        seen_hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (beep) seen_hi = 1;
        end
        chk("beep_div0", 32'(seen_hi), 32'd0);

        // Reset mid-unlock returns to LOCKED and restores pages
        io_wr(8'hD2, 8'hA5, 2);
        io_wr(8'hD2, 8'hA5, 2);
        @(negedge clk);
        addr = 16'h0000; mreq_n = 1'b0; reset = 1'b0;
        #1 chk("rst_async", 32'({ba, rom_cs_n, ram_cs_n, unlocked}), 32'({8'h00, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        mreq_n = 1'b1; reset = 1'b1;
        io_wr(8'hD2, 8'h5A, 2);
        #1 chk("rst_key1_lost", 32'(unlocked), 32'd0);

        // Reset during an IO write discards it
        io_wr(8'hD2, 8'hA5, 2);
        io_wr(8'hD2, 8'h5A, 2);
        #1 chk("reunlock", 32'(unlocked), 32'd1);
        @(negedge clk);
        addr = 16'h00D8; tb_drv = 8'h22; tb_oe = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mem_at(16'h0000);
        chk("rst_io_drop", 32'({ba, unlocked}), 32'({8'h00, 1'b0}));
        mreq_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mintz80_mmu_paged.md
# mintz80_mmu_paged

Clocked, parametrised memory-management unit for the MintZ80 board. It splits the 64 KB Z80 address space into 2^PAGE_BITS equal pages and maps each page to a BANK_W-bit physical bank. Banks below ROM_BANKS select ROM; all others select RAM. Page registers are write-protected by a two-byte unlock key sequence. The block also contains a programmable square-wave beeper, and sits between the CPU bus and the memory chip selects.

## Interface
Parameters:
- PAGE_BITS, 3, log2 of page count (1..3); page index = addr[15:16-PAGE_BITS]
- BANK_W, 8, bank register width
- ROM_BANKS, 4, bank values below this select ROM
- IO_BASE, 8'hD0, IO window base; window = IO_BASE..IO_BASE+15 (low nibble of IO_BASE must be 0)
- DIV_W, 12, beeper divider width (9..15)

Ports:
- clk  in  1  CPU clock; all registers on rising edge
- reset  in  1  reset, asynchronous, active-low
- m1_n  in  1  Z80 M1; IO accesses with m1_n=0 (interrupt ack) ignored
- iorq_n, mreq_n, rd_n, wr_n  in  1 each  Z80 strobes
- addr  in  16  CPU address; addr[7:0] used for IO decode
- data  inout  8  CPU data bus; driven only during decoded IO reads
- ba  out  BANK_W  physical bank for current address
- rom_cs_n  out  1  ROM select, active-low
- ram_cs_n  out  1  RAM select, active-low
- beep  out  1  beeper square wave
- unlocked  out  1  lock FSM in UNLOCKED

## Operation
- IO map (offset from IO_BASE): +0 TONE_LO (divider[7:0]); +1 TONE_HI (bit7 = enable, bits[DIV_W-9:0] = divider high); +2 KEY (write = key byte, read = {7'b0, unlocked}); +8..+8+2^PAGE_BITS-1 PAGE[i]. Other offsets: writes ignored, reads not driven.
- IO write event: iorq_n=0, wr_n=0, m1_n=1, addr[7:4]=IO_BASE[7:4], sampled at clk. It fires exactly once per bus cycle, on the first clk where the qualified strobe is active and the registered previous strobe was inactive. Data is captured on that edge.
- Lock FSM, reset state LOCKED:
  - LOCKED: KEY write of 8'hA5 -> KEY1. Any other write stays LOCKED.
  - KEY1: KEY write of 8'h5A -> UNLOCKED. Any other IO write in the window (any offset, any value) -> LOCKED.
  - UNLOCKED: any KEY write -> LOCKED.
- PAGE[i] writes take effect only in UNLOCKED; otherwise they are silently dropped. TONE writes are never locked.
- Page reset values: PAGE[0] = 0; PAGE[i] = (ROM_BANKS + i - 1) mod 2^BANK_W for i ≥ 1.
- Mapping (combinational): ba = PAGE[addr page index].
  - rom_cs_n = mreq_n | (ba ≥ ROM_BANKS).
  - ram_cs_n = mreq_n | (ba < ROM_BANKS).
  - Exactly one select is low while mreq_n=0.
- Beeper: DIV_W-bit down-counter.
  - While enable=1 and divider≠0: at count 0, reload divider and toggle beep; otherwise decrement. Half-period = divider+1 clocks.
  - enable=0 or divider=0: beep=0 and counter=0 on the next clk.
  - Any TONE write reloads the counter with the new divider on the write edge; beep keeps its level.
- Reads: data is driven combinationally while iorq_n=0, rd_n=0, m1_n=1 and the address decodes to a readable register (see Configuration); otherwise data is high-Z.

## Timing
- Async reset, effective immediately: all PAGE registers to reset values, FSM=LOCKED, divider=0, enable=0, counter=0, beep=0, unlocked=0, prev-strobe=0, data high-Z. This gives ba=0 and, with mreq_n=0, rom_cs_n=0 / ram_cs_n=1.
- Register, FSM and unlocked updates are visible 1 clk after the capturing edge. Z80 IO cycles (≥3 T-states with the wait state) satisfy this.
- ba and the chip selects have zero-cycle (combinational) latency from addr/mreq_n. A memory access immediately after an OUT to PAGE sees the new mapping.
- A held strobe across many clocks produces one write only. Strobe deassert then reassert produces a second write.
- Reset asserted mid-unlock (KEY1) returns the FSM to LOCKED. Reset asserted during an IO cycle discards that write.

## Configuration
- MMU_READBACK_EN defined: PAGE[i] reads return {zero-extended/truncated PAGE[i] in data[BANK_W-1:0] (upper bits 0 if BANK_W<8; low 8 bits if BANK_W>8)}. TONE_LO and TONE_HI read back their stored values (unused TONE_HI bits 0). KEY reads return status.
- Not defined: only KEY (status) is readable. Reads at all other offsets leave data high-Z and there is no page readback logic.

## Test plan
- Reset, then MREQ read at 0x0000 and at 0x2000 -> ba=0 with rom_cs_n=0; then ba=4 (defaults) with ram_cs_n=0, rom_cs_n=1.
- OUT 0xD8←0x10 while LOCKED -> PAGE[0] unchanged. OUT 0xD2←A5, 0xD2←5A -> unlocked=1. OUT 0xD8←0x10 -> address 0x0000 gives ba=0x10, ram_cs_n=0.
- OUT 0xD2←A5, then OUT 0xD0←0x33, then OUT 0xD2←5A -> FSM stays LOCKED (the intervening write aborts KEY1), unlocked=0.
- OUT 0xD0←0x03, 0xD1←0x80 -> beep toggles every 4 clk. OUT 0xD1←0x00 -> beep=0 on next clk.
- In UNLOCKED, hold iorq_n/wr_n low for 5 clk on 0xD2 -> single LOCK transition. Pulse an M1+IORQ ack cycle -> no register changes.
- With MMU_READBACK_EN: IN 0xD9 after reset -> 0x04. Without it: IN 0xD9 -> data high-Z, while IN 0xD2 -> 0x00 or 0x01 per lock state.
